cordic_sched: RTL and testbench

//  Shares one free-running pipelined CORDIC rotator between NREQ requesters.
//  - Round-robin arbiter accepts at most one rotation request per cycle (valid/ready).
//  - Registers the winner's operands onto the CORDIC inputs.
//  - Carries a requester ID down a delay line matched to the CORDIC latency.
//  - Returns each result tagged with its requester ID. Sits between rotation clients and the CORDIC core.

---
 rtl/cordic_sched.sv | 112 +++++++++++
 tb/tb_cordic_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Round-robin front end that time-shares one free-running pipelined CORDIC
// rotator between NREQ requesters and tags each returning result with its owner.
module cordic_sched #(
    parameter int NREQ = 4,
    parameter int IW   = 13,
    parameter int OW   = 13,
    parameter int PW   = 20,
    parameter int LAT  = 17,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*IW-1:0]   i_req_xval,
    input  logic [NREQ*IW-1:0]   i_req_yval,
    input  logic [NREQ*PW-1:0]   i_req_phase,
    output logic [IW-1:0]        o_c_xval,
    output logic [IW-1:0]        o_c_yval,
    output logic [PW-1:0]        o_c_phase,
    input  logic [OW-1:0]        i_c_xval,
    input  logic [OW-1:0]        i_c_yval,
    output logic                 o_res_valid,
    output logic [IDW-1:0]       o_res_id,
    output logic [OW-1:0]        o_res_xval,
    output logic [OW-1:0]        o_res_yval,
    output logic                 o_busy
);

    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_id;
    logic           grant_any;
    logic [IDW:0]   scan_idx;

    // Each tag entry is {valid, id}; entry LAT lines up with the CORDIC output.
    logic [IDW:0]   tag_q [LAT+1];

    // Search starts one past the last accepted requester so every requester
    // gets a turn within NREQ grants.
    always_comb begin
        grant_id    = '0;
        grant_any   = 1'b0;
        scan_idx    = '0;
        o_req_ready = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = {1'b0, last_grant} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ))
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            if (!grant_any && i_req_valid[scan_idx[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[IDW-1:0];
            end
        end
        if (i_rst || !i_en)
            grant_any = 1'b0;
        if (grant_any)
            o_req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant <= IDW'(NREQ - 1);
            o_c_xval   <= '0;
            o_c_yval   <= '0;
            o_c_phase  <= '0;
        end else if (grant_any) begin
            last_grant <= grant_id;
            o_c_xval   <= i_req_xval[int'(grant_id)*IW +: IW];
            o_c_yval   <= i_req_yval[int'(grant_id)*IW +: IW];
            o_c_phase  <= i_req_phase[int'(grant_id)*PW +: PW];
        end else begin
            o_c_xval   <= '0;
            o_c_yval   <= '0;
            o_c_phase  <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= LAT; i++)
                tag_q[i] <= '0;
        end else begin
            tag_q[0] <= {grant_any, grant_any ? grant_id : IDW'(0)};
            for (int i = 1; i <= LAT; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end

    // Consumers cannot stall, so the result stage simply samples the CORDIC
    // output whenever the tail tag says a real request is arriving.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res_valid <= 1'b0;
            o_res_id    <= '0;
            o_res_xval  <= '0;
            o_res_yval  <= '0;
        end else begin
            o_res_valid <= tag_q[LAT][IDW];
            o_res_id    <= tag_q[LAT][IDW-1:0];
            o_res_xval  <= tag_q[LAT][IDW] ? i_c_xval : '0;
            o_res_yval  <= tag_q[LAT][IDW] ? i_c_yval : '0;
        end
    end

    always_comb begin
        o_busy = o_res_valid;
        for (int i = 0; i <= LAT; i++)
            o_busy = o_busy | tag_q[i][IDW];
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched with a pure-delay stub in place of the CORDIC.
module tb_cordic_sched;

    localparam int NREQ = 4;
    localparam int IW   = 13;
    localparam int OW   = 13;
    localparam int PW   = 20;
    localparam int LAT  = 17;
    localparam int IDW  = 2;

    typedef struct {
        int            id;
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        int            due;
    } exp_t;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_en  = 1'b1;
    logic [NREQ-1:0]      i_req_valid = '0;
    logic [NREQ-1:0]      o_req_ready;
    logic [NREQ*IW-1:0]   i_req_xval;
    logic [NREQ*IW-1:0]   i_req_yval;
    logic [NREQ*PW-1:0]   i_req_phase;
    logic [IW-1:0]        o_c_xval;
    logic [IW-1:0]        o_c_yval;
    logic [PW-1:0]        o_c_phase;
    logic [OW-1:0]        i_c_xval;
    logic [OW-1:0]        i_c_yval;
    logic                 o_res_valid;
    logic [IDW-1:0]       o_res_id;
    logic [OW-1:0]        o_res_xval;
    logic [OW-1:0]        o_res_yval;
    logic                 o_busy;

    logic [IW-1:0] req_x  [NREQ];
    logic [IW-1:0] req_y  [NREQ];
    logic [PW-1:0] req_ph [NREQ];

    logic [IW-1:0] stub_x [LAT];
    logic [IW-1:0] stub_y [LAT];

    exp_t          sb_q [$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            mlast = NREQ - 1;
    logic [IW-1:0] prev_x  = '0;
    logic [IW-1:0] prev_y  = '0;
    logic [PW-1:0] prev_ph = '0;

    cordic_sched #(.NREQ(NREQ), .IW(IW), .OW(OW), .PW(PW), .LAT(LAT)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_xval  (i_req_xval),
        .i_req_yval  (i_req_yval),
        .i_req_phase (i_req_phase),
        .o_c_xval    (o_c_xval),
        .o_c_yval    (o_c_yval),
        .o_c_phase   (o_c_phase),
        .i_c_xval    (i_c_xval),
        .i_c_yval    (i_c_yval),
        .o_res_valid (o_res_valid),
        .o_res_id    (o_res_id),
        .o_res_xval  (o_res_xval),
        .o_res_yval  (o_res_yval),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Stub rotator: LAT-cycle passthrough of x/y.
    always @(posedge i_clk) begin
        stub_x[0] <= o_c_xval;
        stub_y[0] <= o_c_yval;
        for (int i = 1; i < LAT; i++) begin
            stub_x[i] <= stub_x[i-1];
            stub_y[i] <= stub_y[i-1];
        end
    end
    assign i_c_xval = stub_x[LAT-1];
    assign i_c_yval = stub_y[LAT-1];

    always_comb begin
        i_req_xval  = '0;
        i_req_yval  = '0;
        i_req_phase = '0;
        for (int k = 0; k < NREQ; k++) begin
            i_req_xval[k*IW +: IW]  = req_x[k];
            i_req_yval[k*IW +: IW]  = req_y[k];
            i_req_phase[k*PW +: PW] = req_ph[k];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic en, input int n);
        i_req_valid = v;
        i_en        = en;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pulseReset();
        i_rst       = 1'b1;
        i_req_valid = '0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Monitor: reference arbiter, issue-register check and result scoreboard.
    always @(negedge i_clk) begin
        int            g;
        int            idx;
        logic [NREQ-1:0] exp_rdy;
        exp_t          e;

        checkOutput("c_xval",  64'(o_c_xval),  64'(prev_x));
        checkOutput("c_yval",  64'(o_c_yval),  64'(prev_y));
        checkOutput("c_phase", 64'(o_c_phase), 64'(prev_ph));

        if (!i_rst) begin
            checkOutput("busy", 64'(o_busy), 64'(sb_q.size() != 0));
            if (o_res_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_result", 64'(o_res_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("res_id",  64'(o_res_id),   64'(e.id));
                    checkOutput("res_x",   64'(o_res_xval), 64'(e.x));
                    checkOutput("res_y",   64'(o_res_yval), 64'(e.y));
                    checkOutput("res_due", 64'(cyc),        64'(e.due));
                end
            end else begin
                checkOutput("res_idle_zero", {o_res_xval, o_res_yval}, 64'd0);
            end
        end

        g = -1;
        if (!i_rst && i_en) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (mlast + k) % NREQ;
                if (g < 0 && i_req_valid[idx])
                    g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0)
            exp_rdy[g] = 1'b1;
        checkOutput("ready", 64'(o_req_ready), 64'(exp_rdy));

        if (g >= 0) begin
            sb_q.push_back('{id: g, x: req_x[g], y: req_y[g], due: cyc + LAT + 2});
            prev_x  = req_x[g];
            prev_y  = req_y[g];
            prev_ph = req_ph[g];
            mlast   = g;
        end else begin
            prev_x  = '0;
            prev_y  = '0;
            prev_ph = '0;
        end

        if (i_rst) begin
            sb_q.delete();
            mlast = NREQ - 1;
        end
    end

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            req_x[k]  = '0;
            req_y[k]  = '0;
            req_ph[k] = '0;
        end
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        $display("[TB] single request from requester 0");
        req_x[0]  = 13'h0123;
        req_y[0]  = 13'h0456;
        req_ph[0] = 20'h12345;
        i_req_valid = 4'b0001;
        @(negedge i_clk);
        checkOutput("t1_ready0", 64'(o_req_ready), 64'h1);
        @(posedge i_clk);
        #1;
        i_req_valid = '0;
        @(negedge i_clk);
        checkOutput("t1_cx", 64'(o_c_xval),  64'h0123);
        checkOutput("t1_cp", 64'(o_c_phase), 64'h12345);
        applyStimulus(4'b0000, 1'b1, 24);

        $display("[TB] all requesters valid after reset");
        pulseReset();
        for (int k = 0; k < NREQ; k++) begin
            req_x[k]  = IW'(13'h0100 * (k + 1) + k);
            req_y[k]  = IW'(13'h1000 - 13'h0011 * (k + 1));
            req_ph[k] = PW'(20'h10000 * k + 20'h00321);
        end
        applyStimulus(4'b1111, 1'b1, 12);
        applyStimulus(4'b0000, 1'b1, 24);

        $display("[TB] requesters 1 and 3 alternating");
        applyStimulus(4'b0010, 1'b1, 1);
        applyStimulus(4'b1010, 1'b1, 200);
        applyStimulus(4'b0000, 1'b1, 24);

        $display("[TB] reset discards in-flight work");
        pulseReset();
        applyStimulus(4'b0001, 1'b1, 8);
        applyStimulus(4'b0000, 1'b1, 2);
        pulseReset();
        applyStimulus(4'b0000, 1'b1, 25);

        $display("[TB] enable gating");
        applyStimulus(4'b1111, 1'b1, 3);
        applyStimulus(4'b1111, 1'b0, 20);
        applyStimulus(4'b1111, 1'b1, 6);
        applyStimulus(4'b0000, 1'b1, 25);

        @(negedge i_clk);
        checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
